spi_boot_loader: RTL

//  Parametrised SPI-slave boot loader. Holds the Atom off external SRAM while a host streams

---
 rtl/spi_boot_loader_if.sv | 29 ++
 rtl/spi_boot_loader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/spi_boot_loader_if.sv
// Signal bundle for the SPI boot loader: SPI slave pins, loader status,
// the Atom-side SRAM bus and the external SRAM pins.
interface spi_boot_loader_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
);
    logic              SCK, SSEL, MOSI, MISO;
    logic              booting, progress, boot_error;
    logic              atom_RAMCS_b, atom_RAMOE_b, atom_RAMWE_b;
    logic [ADDR_W-1:0] atom_RAMA;
    logic [DATA_W-1:0] atom_RAMDin;
    logic              ext_RAMCS_b, ext_RAMOE_b, ext_RAMWE_b;
    logic [ADDR_W-1:0] ext_RAMA;
    logic [DATA_W-1:0] ext_RAMDin;

    modport slave (
        input  SCK, SSEL, MOSI,
        input  atom_RAMCS_b, atom_RAMOE_b, atom_RAMWE_b, atom_RAMA, atom_RAMDin,
        output MISO, booting, progress, boot_error,
        output ext_RAMCS_b, ext_RAMOE_b, ext_RAMWE_b, ext_RAMA, ext_RAMDin
    );

    modport master (
        output SCK, SSEL, MOSI,
        output atom_RAMCS_b, atom_RAMOE_b, atom_RAMWE_b, atom_RAMA, atom_RAMDin,
        input  MISO, booting, progress, boot_error,
        input  ext_RAMCS_b, ext_RAMOE_b, ext_RAMWE_b, ext_RAMA, ext_RAMDin
    );
endinterface

// File: rtl/spi_boot_loader.sv
// SPI-slave boot loader: framed WRITE/BOOT commands fill external SRAM, then hand it to the Atom.
// Optional BOOT_CHECKSUM_EN: trailing two's-complement checksum per WRITE frame, BOOT gated on no error.
module spi_boot_loader #(
    parameter int         ADDR_W    = 18,
    parameter int         DATA_W    = 8,
    parameter int         WE_CYCLES = 2,
    parameter logic [3:0] STATUS_ID = 4'hA
) (
    input  logic             clk,
    input  logic             reset,
    spi_boot_loader_if.slave bus
);
    localparam int            CW        = $clog2(WE_CYCLES + 2) + 1;
    localparam logic [CW-1:0] WE_N      = CW'(WE_CYCLES);
    localparam logic [CW-1:0] WR_LAST   = CW'(WE_CYCLES + 1);
    localparam logic [7:0]    CMD_WRITE = 8'h02;
    localparam logic [7:0]    CMD_BOOT  = 8'h03;

    typedef enum logic [2:0] {S_CMD, S_ADDR, S_LEN, S_DATA, S_WR, S_SKIP, S_DONE, S_CSUM} state_t;
    state_t state, state_nx;

    logic [2:0] sck_s, ssel_s;
    logic [1:0] mosi_s;
    logic [2:0] bitcnt;
    logic [6:0] sh;
    logic [7:0] rx_data, miso_sh, pend_data;
    logic       byte_rx, pend_vld, booting_r, boot_error, overrun, we_b;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [15:0]       rem;
    logic [1:0]        idx;
    logic [CW-1:0]     wr_cnt;

    wire sck_rise  = sck_s[1] & ~sck_s[2];
    wire sck_fall  = ~sck_s[1] & sck_s[2];
    wire ssel_hi   = ssel_s[1];
    wire ssel_fall = ~ssel_s[1] & ssel_s[2];
    wire wr_done   = (state == S_WR) && (wr_cnt == WR_LAST);
    // A buffered byte is always consumed ahead of a freshly received one.
    wire in_vld    = ~ssel_hi && (state != S_WR) && (state != S_DONE) && (byte_rx || pend_vld);
    wire [7:0] in_byte = pend_vld ? pend_data : rx_data;
    wire [ADDR_W+7:0] addr_cat = {addr, in_byte};
    wire [7:0] status  = {booting_r, boot_error, overrun, 1'b0, STATUS_ID};

`ifdef BOOT_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
    wire boot_ok = ~boot_error;
    logic [7:0] sum;
    always_ff @(posedge clk or posedge reset)
        if (reset)       sum <= 8'd0;
        else if (in_vld) sum <= (state == S_CMD) ? in_byte : 8'(sum + in_byte);
`else
    localparam state_t S_TAIL = S_SKIP;
    wire boot_ok = 1'b1;
`endif

    // SPI receive / status shift-out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_s <= 3'b000; ssel_s <= 3'b111; mosi_s <= 2'b00;
            bitcnt <= 3'd0; sh <= 7'd0; rx_data <= 8'd0; byte_rx <= 1'b0; miso_sh <= 8'hFF;
        end else begin
            sck_s   <= {sck_s[1:0], bus.SCK};
            ssel_s  <= {ssel_s[1:0], bus.SSEL};
            mosi_s  <= {mosi_s[0], bus.MOSI};
            byte_rx <= 1'b0;
            if (ssel_hi) bitcnt <= 3'd0;
            else if (sck_rise) begin
                sh     <= {sh[5:0], mosi_s[1]};
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    byte_rx <= 1'b1;
                    rx_data <= {sh, mosi_s[1]};
                end
            end
            if (ssel_hi)        miso_sh <= 8'hFF;
            else if (ssel_fall) miso_sh <= status;
            else if (sck_fall)  miso_sh <= {miso_sh[6:0], 1'b1};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_DONE: state_nx = S_DONE;
            S_WR: if (wr_done) state_nx = ssel_hi ? S_CMD : ((rem == 16'd0) ? S_TAIL : S_DATA);
            default:
                if (ssel_hi) state_nx = S_CMD;
                else if (in_vld) begin
                    case (state)
                        S_CMD:
                            if (in_byte == CMD_WRITE)                state_nx = S_ADDR;
                            else if (in_byte == CMD_BOOT && boot_ok) state_nx = S_DONE;
                            else                                     state_nx = S_SKIP;
                        S_ADDR: if (idx == 2'd2) state_nx = S_LEN;
                        S_LEN:  if (idx == 2'd1) state_nx = S_DATA;
                        S_DATA: state_nx = S_WR;
                        S_CSUM: state_nx = S_SKIP;
                        default: ;
                    endcase
                end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_CMD; booting_r <= 1'b1; boot_error <= 1'b0; overrun <= 1'b0; we_b <= 1'b1;
            addr <= '0; wdata <= '0; rem <= 16'd0; idx <= 2'd0; wr_cnt <= '0;
            pend_vld <= 1'b0; pend_data <= 8'd0;
        end else begin
            state <= state_nx;
            we_b  <= 1'b1;
            if (in_vld && pend_vld) begin
                pend_vld  <= byte_rx;
                pend_data <= rx_data;
            end else if (byte_rx && state == S_WR) begin
                if (pend_vld) begin
                    overrun    <= 1'b1;
                    boot_error <= 1'b1;
                end else begin
                    pend_vld  <= 1'b1;
                    pend_data <= rx_data;
                end
            end
            if (ssel_hi && (state != S_WR || wr_done)) pend_vld <= 1'b0;
            // Strobe: 1 setup clk, WE_CYCLES low, 1 hold clk, then advance.
            if (state == S_WR) begin
                wr_cnt <= wr_cnt + 1'b1;
                we_b   <= (wr_cnt >= WE_N);
                if (wr_done) begin
                    addr <= addr + 1'b1;
                    rem  <= rem - 16'd1;
                end
            end
            if (in_vld) begin
                case (state)
                    S_CMD: begin
                        idx <= 2'd0;
                        if (in_byte == CMD_BOOT && boot_ok) booting_r <= 1'b0;
                    end
                    S_ADDR: begin
                        addr <= addr_cat[ADDR_W-1:0];
                        idx  <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                    end
                    S_LEN: begin
                        rem <= {rem[7:0], in_byte};
                        idx <= idx + 2'd1;
                    end
                    S_DATA: begin
                        wdata  <= in_byte;
                        wr_cnt <= '0;
                    end
`ifdef BOOT_CHECKSUM_EN
                    S_CSUM: if (8'(sum + in_byte) != 8'd0) boot_error <= 1'b1;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.MISO        = miso_sh[7];
    assign bus.booting     = booting_r;
    assign bus.progress    = byte_rx;
    assign bus.boot_error  = boot_error;
    assign bus.ext_RAMCS_b = booting_r ? 1'b0  : bus.atom_RAMCS_b;
    assign bus.ext_RAMOE_b = booting_r ? 1'b1  : bus.atom_RAMOE_b;
    assign bus.ext_RAMWE_b = booting_r ? we_b  : bus.atom_RAMWE_b;
    assign bus.ext_RAMA    = booting_r ? addr  : bus.atom_RAMA;
    assign bus.ext_RAMDin  = booting_r ? wdata : bus.atom_RAMDin;
endmodule
